// File: rtl/div_wb_merge.sv
// Writeback merge stage: folds fixed-latency divider results into the single
// register-file write port, buffering results that collide with W-stage writes.
module div_wb_merge #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic            div_valid,
  input  logic [4:0]      div_rd,
  input  logic [XLEN-1:0] div_result,
  input  logic [XLEN-1:0] div_pc,
  input  logic [31:0]     div_inst,
  input  logic            w_regwrite,
  input  logic [4:0]      w_rd,
  input  logic [XLEN-1:0] w_data,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            div_retire,
  output logic [XLEN-1:0] div_retire_pc,
  output logic [31:0]     div_retire_inst,
  output logic            div_issue_block,
  output logic [31:0]     div_busy,
  output logic            overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [4:0]      rd_mem   [DEPTH];
  logic [XLEN-1:0] res_mem  [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [31:0]     inst_mem [DEPTH];
  logic [DEPTH-1:0] live;

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count, inflight;

  logic w_take, fifo_empty, fifo_full;
  logic pop, bypass, push_req, push, drop, push_live;

  // W stage owns the port whenever it writes a real register; it never stalls.
  always_comb begin
    w_take     = w_regwrite && (w_rd != 5'd0);
    fifo_empty = (count == '0);
    fifo_full  = (count == DEPTH_C);
    pop        = !rst && !w_take && !fifo_empty;
    bypass     = !rst && !w_take && fifo_empty && div_valid;
    push_req   = div_valid && !bypass;
    push       = push_req && (!fifo_full || pop);
    drop       = push_req && !push;
    // A same-cycle W write to the same register makes this result stale.
    push_live  = (div_rd != 5'd0) && !(w_take && (div_rd == w_rd));
  end

  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    rf_we           = 1'b0;
    rf_waddr        = '0;
    rf_wdata        = '0;
    div_retire      = 1'b0;
    div_retire_pc   = '0;
    div_retire_inst = '0;
    if (!rst && w_take) begin
      rf_we    = 1'b1;
      rf_waddr = w_rd;
      rf_wdata = w_data;
    end else if (pop) begin
      rf_we           = live[head];
      rf_waddr        = rd_mem[head];
      rf_wdata        = res_mem[head];
      div_retire      = 1'b1;
      div_retire_pc   = pc_mem[head];
      div_retire_inst = inst_mem[head];
    end else if (bypass) begin
      rf_we           = (div_rd != 5'd0);
      rf_waddr        = div_rd;
      rf_wdata        = div_result;
      div_retire      = 1'b1;
      div_retire_pc   = div_pc;
      div_retire_inst = div_inst;
    end
  end

  always_comb begin
    div_busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i]) div_busy[rd_mem[i]] = 1'b1;
    end
    div_busy[0] = 1'b0;
  end

  assign div_issue_block = ({1'b0, count} + {1'b0, inflight}) >= {1'b0, DEPTH_C};

  // NOTE: sequential state uses non-blocking assignments only; later
  // assignments in this block (push) deliberately override earlier ones (pop).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= '0;
      overflow <= 1'b0;
      live     <= '0;
    end else begin
      if (pop)  head <= head + PW'(1);
      if (push) tail <= tail + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      case ({issue_valid, div_valid})
        2'b10:   if (inflight != DEPTH_C) inflight <= inflight + CW'(1);
        2'b01:   if (inflight != '0)      inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
      if (drop) overflow <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        if (w_take && live[i] && (rd_mem[i] == w_rd)) live[i] <= 1'b0;
      end
      if (pop)  live[head] <= 1'b0;
      if (push) live[tail] <= push_live;
    end
  end

  // NOTE: payload storage is not reset; the live bits and count gate its use.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail]   <= div_rd;
      res_mem[tail]  <= div_result;
      pc_mem[tail]   <= div_pc;
      inst_mem[tail] <= div_inst;
    end
  end

endmodule

// File: tb/tb_div_wb_merge.sv
// Bench for div_wb_merge: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_div_wb_merge;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            issue_valid, div_valid, w_regwrite;
  logic [4:0]      div_rd, w_rd;
  logic [XLEN-1:0] div_result, div_pc, w_data;
  logic [31:0]     div_inst;
  logic            rf_we, div_retire, div_issue_block, overflow;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata, div_retire_pc;
  logic [31:0]     div_retire_inst, div_busy;

  div_wb_merge #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid),
    .div_valid(div_valid), .div_rd(div_rd), .div_result(div_result),
    .div_pc(div_pc), .div_inst(div_inst),
    .w_regwrite(w_regwrite), .w_rd(w_rd), .w_data(w_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .div_retire(div_retire), .div_retire_pc(div_retire_pc),
    .div_retire_inst(div_retire_inst), .div_issue_block(div_issue_block),
    .div_busy(div_busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] res;
    logic [31:0] pc;
    logic [31:0] inst;
    bit          live;
  } ent_t;

  ent_t q[$];
  int   inflight_m;
  bit   ovf_m;
  int   tests = 0;
  int   fails = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    inflight_m = 0;
    ovf_m = 0;
  endtask

  // Expected outputs from the model state and the current inputs.
  task automatic compare();
    bit          e_we, e_ret, wt;
    logic [4:0]  e_addr;
    logic [31:0] e_data, e_pc, e_inst, e_busy;
    bit          e_block;
    e_we = 0; e_ret = 0; e_addr = 0; e_data = 0; e_pc = 0; e_inst = 0; e_busy = 0;
    if (!rst) begin
      wt = w_regwrite && (w_rd != 0);
      if (wt) begin
        e_we = 1; e_addr = w_rd; e_data = w_data;
      end else if (q.size() > 0) begin
        e_ret = 1; e_pc = q[0].pc; e_inst = q[0].inst;
        e_we = q[0].live && (q[0].rd != 0);
        e_addr = q[0].rd; e_data = q[0].res;
      end else if (div_valid) begin
        e_ret = 1; e_pc = div_pc; e_inst = div_inst;
        e_we = (div_rd != 0); e_addr = div_rd; e_data = div_result;
      end
      foreach (q[i]) if (q[i].live && q[i].rd != 0) e_busy = e_busy | (32'd1 << q[i].rd);
    end
    e_block = !rst && ((q.size() + inflight_m) >= DEPTH);
    check("rf_we", rf_we, e_we);
    if (e_we) begin
      check("rf_waddr", rf_waddr, e_addr);
      check("rf_wdata", rf_wdata, e_data);
    end
    check("div_retire", div_retire, e_ret);
    if (e_ret) begin
      check("retire_pc", div_retire_pc, e_pc);
      check("retire_inst", div_retire_inst, e_inst);
    end
    check("div_busy", div_busy, e_busy);
    check("issue_block", div_issue_block, e_block);
    check("overflow", overflow, ovf_m);
  endtask

  // State advance using the inputs present at the rising edge.
  task automatic update();
    bit   wt, popped, bypassed;
    ent_t e;
    if (rst) begin
      model_reset();
      return;
    end
    wt = w_regwrite && (w_rd != 0);
    popped = !wt && q.size() > 0;
    bypassed = !wt && q.size() == 0 && div_valid;
    if (wt) foreach (q[i]) if (q[i].rd == w_rd) q[i].live = 0;
    if (popped) void'(q.pop_front());
    if (div_valid && !bypassed) begin
      if (q.size() < DEPTH) begin
        e.rd = div_rd; e.res = div_result; e.pc = div_pc; e.inst = div_inst;
        e.live = !(wt && div_rd == w_rd);
        q.push_back(e);
      end else begin
        ovf_m = 1;
      end
    end
    if (issue_valid) inflight_m++;
    if (div_valid) inflight_m--;
    if (inflight_m < 0) inflight_m = 0;
    if (inflight_m > DEPTH) inflight_m = DEPTH;
  endtask

  task automatic step();
    #1;
    compare();
    @(posedge clk);
    update();
    @(negedge clk);
  endtask

  task automatic drive(bit iv, bit dv, logic [4:0] drd, logic [31:0] dres,
                       bit wr, logic [4:0] wrd, logic [31:0] wd);
    issue_valid = iv;
    div_valid   = dv;
    div_rd      = drd;
    div_result  = dres;
    div_pc      = 32'h1000 + dres;
    div_inst    = {dres[15:0], 11'h0, drd};
    w_regwrite  = wr;
    w_rd        = wrd;
    w_data      = wd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    drive(1, 1, 5'd5, 32'h55, 0, 0, 0);
    @(negedge clk);
    #1;
    check("rst_rf_we", rf_we, 0);
    check("rst_retire", div_retire, 0);
    check("rst_busy", div_busy, 0);
    check("rst_block", div_issue_block, 0);
    step();
    rst = 1'b0;
    idle();

    // Lone divide: bypass in the arrival cycle.
    drive(1, 0, 0, 0, 0, 0, 0);
    step();
    idle();
    repeat (7) step();
    drive(0, 1, 5'd5, 32'h7, 0, 0, 0);
    #1;
    check("lone_we", rf_we, 1);
    check("lone_waddr", rf_waddr, 5);
    check("lone_wdata", rf_wdata, 32'h7);
    check("lone_retire", div_retire, 1);
    step();
    idle();
    #1;
    check("lone_busy", div_busy, 0);
    check("lone_block", div_issue_block, 0);

    // Collision with a W write: result buffered, drained next idle cycle.
    drive(0, 1, 5'd6, 32'h66, 1, 5'd3, 32'h11);
    #1;
    check("coll_waddr", rf_waddr, 3);
    check("coll_wdata", rf_wdata, 32'h11);
    check("coll_retire", div_retire, 0);
    step();
    idle();
    #1;
    check("coll_busy6", div_busy[6], 1);
    check("coll_drain_addr", rf_waddr, 6);
    check("coll_drain_data", rf_wdata, 32'h66);
    check("coll_drain_ret", div_retire, 1);
    step();
    #1;
    check("coll_empty_busy", div_busy, 0);

    // Kill: a younger W write to the same register makes the entry stale.
    drive(0, 1, 5'd6, 32'h99, 1, 5'd3, 32'h11);
    step();
    drive(0, 0, 0, 0, 1, 5'd6, 32'h22);
    #1;
    check("kill_busy_same", div_busy[6], 1);
    check("kill_wdata", rf_wdata, 32'h22);
    step();
    idle();
    #1;
    check("kill_busy_next", div_busy[6], 0);
    check("kill_no_write", rf_we, 0);
    check("kill_retire", div_retire, 1);
    check("kill_retire_pc", div_retire_pc, 32'h1099);
    step();

    // Issue block with W busy every cycle.
    repeat (4) begin
      drive(1, 0, 0, 0, 1, 5'd1, 32'h1);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 5'(11 + i), 32'(32'hA0 + i), 1, 5'd1, 32'h1);
      step();
    end
    #1;
    check("blk_set", div_issue_block, 1);
    idle();
    #1;
    check("blk_drain_addr", rf_waddr, 11);
    step();
    #1;
    check("blk_clear", div_issue_block, 0);

    // Overflow: fill to DEPTH, then one more result is dropped.
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 5'(14 + i), 32'(32'hB0 + i), 1, 5'd1, 32'h1);
      step();
    end
    drive(0, 1, 5'd16, 32'hC0, 1, 5'd1, 32'h1);
    #1;
    check("ovf_before", overflow, 0);
    check("ovf_full_block", div_issue_block, 1);
    step();
    #1;
    check("ovf_set", overflow, 1);
    check("ovf_dropped_busy", div_busy[16], 0);
    check("ovf_block", div_issue_block, 1);
    idle();
    repeat (4) step();
    #1;
    check("ovf_sticky", overflow, 1);
    check("ovf_drained_busy", div_busy, 0);

    // rd=0 result retires without a write.
    drive(0, 1, 5'd0, 32'hDD, 0, 0, 0);
    #1;
    check("rd0_we", rf_we, 0);
    check("rd0_retire", div_retire, 1);
    step();

    // Reset with two buffered entries.
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 5'(9 + i), 32'(32'hE0 + i), 1, 5'd1, 32'h1);
      step();
    end
    idle();
    #1;
    check("prerst_busy", div_busy, 32'h0000_0600);
    rst = 1'b1;
    drive(0, 1, 5'd7, 32'h77, 0, 0, 0);
    model_reset();
    #1;
    check("rst_busy_clr", div_busy, 0);
    check("rst_no_retire", div_retire, 0);
    check("rst_no_we", rf_we, 0);
    check("rst_ovf_clr", overflow, 0);
    step();
    rst = 1'b0;
    idle();
    #1;
    check("postrst_retire", div_retire, 0);
    step();

    // Randomized traffic in alternating W-heavy and W-light phases.
    for (int c = 0; c < 3000; c++) begin
      int wprob;
      wprob = ((c / 200) % 2 == 0) ? 85 : 30;
      if (c == 1500) begin
        rst = 1'b1;
        model_reset();
        step();
        rst = 1'b0;
      end
      issue_valid = ($urandom_range(99) < 40);
      div_valid   = ($urandom_range(99) < 40);
      div_rd      = 5'($urandom_range(7));
      div_result  = $urandom;
      div_pc      = $urandom;
      div_inst    = $urandom;
      w_regwrite  = ($urandom_range(99) < wprob);
      w_rd        = 5'($urandom_range(7));
      w_data      = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_wb_merge.md
# div_wb_merge

Writeback merge stage downstream of the divider unit. It combines the fixed-latency divider result stream with the main pipeline's W-stage register-file write into one register-file write port. Divider results that collide with a W-stage write are held in a small FIFO and drained in idle W cycles. The block also blocks new divide issue when buffer space could run out, and publishes a busy vector of registers with buffered, unwritten results.

## Interface
- DEPTH, 4, divider result FIFO entries (power of 2, ≥2)
- XLEN, 32, data/PC width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- issue_valid  in  1  divide accepted into divider this cycle
- div_valid  in  1  divider result valid
- div_rd  in  5  divider destination register
- div_result  in  XLEN  quotient/remainder
- div_pc  in  XLEN  PC of divide instruction
- div_inst  in  32  divide instruction word
- w_regwrite  in  1  W stage writes register file this cycle
- w_rd  in  5  W destination register
- w_data  in  XLEN  W write data
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  XLEN  register-file write data
- div_retire  out  1  a divider result is committed or discarded this cycle
- div_retire_pc  out  XLEN  PC of that divide
- div_retire_inst  out  32  instruction word of that divide
- div_issue_block  out  1  decode must not issue a divide
- div_busy  out  32  bit r set if a buffered entry targets r (bit 0 always 0)
- overflow  out  1  sticky: result dropped because FIFO full

## Operation
- State: FIFO of {rd, result, pc, inst, live}, with head/tail pointers and count (0..DEPTH); inflight counter (0..DEPTH); overflow flag.
- Priority: W stage first. It can never be stalled by this block. If w_regwrite and w_rd≠0, the RF port carries the W write.
- Source selection when the W stage does not take the port (no w_regwrite, or w_rd=0):
  - FIFO non-empty: pop the head. If the head is live, write it to RF.
  - FIFO empty and div_valid: bypass, writing div_* to RF in the same cycle with no push.
  - Otherwise rf_we=0.
- Push: div_valid and not bypassed. Push into the tail if count<DEPTH (or if a pop occurs this cycle); otherwise drop the result and set overflow.
- Kill (younger-wins): when the W stage writes rd=r≠0, every live FIFO entry with rd=r is cleared to not-live in the same cycle. An incoming div_valid with div_rd=r is pushed not-live.
- rd=0: divider results with div_rd=0 are never written to RF. They are still pushed or bypassed so they retire.
- Retire: div_retire pulses on every pop and every bypass, live or not, with that entry's pc/inst. Non-live pops assert div_retire with rf_we from W only.
- inflight: +1 on issue_valid, −1 on div_valid. Both in one cycle leaves it unchanged. Saturates at 0 and DEPTH.
- div_issue_block = (count + inflight) ≥ DEPTH, using registered values.
- div_busy = OR of decoded rd over live entries, combinational from current state. Entries killed or popped this cycle still count until the next edge.

## Timing
- Reset: FIFO empty, pointers 0, count 0, inflight 0, overflow 0.
- While rst is high, rf_we=0 and div_retire=0 regardless of inputs. All other outputs follow the reset state: div_busy=0, div_issue_block=0.
- rf_*, div_retire* are combinational from state and the current inputs, sampled by the RF on the same rising edge.
- Latency: bypass 0 cycles. A buffered result writes in the first cycle with no W write after all older entries drain.
- Push, pop, kill and counter updates take effect on the rising edge. A simultaneous push and pop with FIFO full is legal, and count is unchanged.
- Pointers wrap modulo DEPTH.
- overflow clears only on rst.
- Reset mid-drain discards all entries without retire pulses.

## Test plan
- Lone divide: issue_valid, then 8 cycles later div_valid rd=5 result=0x7, no W write. Required: rf_we=1, waddr=5, wdata=0x7 the same cycle; div_retire=1; count stays 0.
- Collision: div_valid rd=6 with w_regwrite rd=3 data=0x11. Required: RF writes x3=0x11 and count=1, div_busy[6]=1. Next idle cycle: x6 written, div_retire=1, count=0.
- Kill: rd=6 buffered, then W writes rd=6 data=0x22. Required: entry not-live and div_busy[6]=0 next cycle. Drain produces div_retire=1 with no x6 write, and x6 keeps 0x22.
- Issue block: DEPTH=4, W writing every cycle, 3 results buffered plus 1 inflight. Required: div_issue_block=1. It clears after one idle-W drain with no new issue.
- Overflow: force div_valid with count=4 and W writing. Required: result dropped, count=4, overflow=1 until rst.
- rd=0 and reset: div_valid rd=0 gives rf_we=0 and div_retire=1. Asserting rst with 2 buffered entries gives count=0, div_busy=0, and no retire.
